pipe_fetch_queue: RTL and testbench
===================================

// Module: pipe_fetch_queue
// PURPOSE
//  Instruction fetch stage: the producer end of the instruction stream that the main decoder consumes.
//  Owns the PC and issues word reads to instruction memory over a req/ack handshake.
//  Buffers returned instructions with their PCs in a DEPTH-entry FIFO.
//  Presents them to the decode stage with a valid/ready handshake.
//  A redirect (branch taken) flushes the FIFO and discards any stale in-flight read.
// PARAMETERS
//  DEPTH     4      FIFO entries; power of 2, >= 2
//  RESET_PC  32'h0  PC loaded at reset
// PORTS
//  clk         in   1   clock, all state on rising edge
//  reset_n     in   1   asynchronous, active-low reset
//  ImemReq     out  1   read request to instruction memory
//  ImemAddr    out  32  word address of request (PC, bits[1:0]=0)
//  ImemAck     in   1   response valid; ImemRData sampled this cycle
//  ImemRData   in   32  instruction word
//  InstrValid  out  1   FIFO head valid toward decode
//  InstrReady  in   1   decode accepts head (pop when InstrValid&InstrReady)
//  InstrD      out  32  FIFO head instruction
//  PCD         out  32  PC of FIFO head instruction
//  Redirect    in   1   flush and refetch from RedirectPC
//  RedirectPC  in   32  new fetch PC; bits[1:0] forced to 0
//  OpD         out  2   [PREDECODE_EN] InstrD[27:26]
//  FunctD      out  6   [PREDECODE_EN] InstrD[25:20]
//  BranchHintD out  1   [PREDECODE_EN] OpD==2'b10
// BEHAVIOUR
//  Reset (async, reset_n=0): PC=RESET_PC, FIFO empty, FSM=IDLE.
//   ImemReq=0, InstrValid=0, ImemAddr=RESET_PC; InstrD/PCD/OpD/FunctD/BranchHintD=0.
//  Memory handshake: at most one outstanding read.
//   ImemReq and ImemAddr are held stable from assertion until the ImemAck cycle; ImemAck is ignored when ImemReq=0.
//  FSM states:
//   IDLE    -> REQ when no Redirect and count<DEPTH (count = occupancy after this cycle's pop).
//   REQ     ImemReq=1, ImemAddr=PC.
//           ImemAck & !Redirect: push {PC,ImemRData}, PC+=4, -> IDLE.
//           Redirect & !ImemAck: -> DISCARD.
//           Redirect & ImemAck: drop data -> IDLE.
//   DISCARD ImemReq=1, stale address held; on ImemAck drop data -> IDLE.
//           A further Redirect here only updates PC.
//  Throughput: one instruction per 2 cycles minimum (REQ/IDLE alternation); no next-request issue in the ack cycle.
//  Latency: ImemAck in cycle N -> InstrValid=1 with that word in N+1 (no bypass).
//  FIFO:
//   Push and pop in the same cycle: count unchanged.
//   Push never occurs when full, because a request is issued only with a free slot.
//   Pop when empty is impossible, since InstrValid=0.
//   Pointers wrap modulo DEPTH.
//  Redirect (any state):
//   FIFO cleared next cycle (InstrValid=0 in N+1); any same-cycle pop is void.
//   PC = {RedirectPC[31:2],2'b00}.
//   Redirect has priority over push and pop.
//  PC arithmetic: 32-bit, wraps 32'hFFFF_FFFC -> 32'h0 silently.
//  Output registers/FIFO head remain stable while InstrValid & !InstrReady.
//  Reset asserted mid-request: all state cleared immediately.
//   An ImemAck in the first cycle after deassertion is ignored (ImemReq=0).
// CONFIGURATION
//  PREDECODE_EN defined: OpD, FunctD and BranchHintD are produced.
//   They are derived combinationally from the FIFO head and are 0 when InstrValid=0.
//  PREDECODE_EN undefined: these ports are absent; the decoder extracts its fields from InstrD.
// TESTING
//  1. Reset, ack 1 cycle after each req, InstrReady=1
//     -> ImemAddr 0,4,8,...; InstrD/PCD in order; InstrValid 1 cycle after each ack.
//  2. InstrReady=0, DEPTH=4
//     -> exactly 4 acks accepted, ImemReq stays 0, head stable at PC 0.
//     Raise InstrReady -> fetch resumes at PC 0x10.
//  3. Redirect to 0x103 while REQ to 0x8 pending, ack 3 cycles later
//     -> ImemReq held on 0x8, data dropped, next ImemAddr=0x100, FIFO empty meanwhile.
//  4. Redirect coincident with ImemAck and with a pop
//     -> word dropped, FIFO empty next cycle, next ImemAddr=RedirectPC.
//  5. RESET_PC=32'hFFFF_FFFC -> ImemAddr FFFF_FFFC then 0000_0000.
//  6. PREDECODE_EN, head=32'hEA000004 -> OpD=2'b10, FunctD=6'b100000, BranchHintD=1.
//     Head=32'hE5912000 -> OpD=01, FunctD=011001, BranchHintD=0.

Source files
------------

// File: rtl/pipe_fetch_queue.sv
// Instruction fetch stage: owns the PC, issues single-outstanding word reads, and buffers {PC, instr} in a FIFO for decode.
// Optional feature macro: PREDECODE_EN adds the OpD/FunctD/BranchHintD predecode outputs.
module pipe_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ImemReq,
  output logic [31:0] ImemAddr,
  input  logic        ImemAck,
  input  logic [31:0] ImemRData,
  output logic        InstrValid,
  input  logic        InstrReady,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  input  logic        Redirect,
  input  logic [31:0] RedirectPC
`ifdef PREDECODE_EN
  ,
  output logic [1:0]  OpD,
  output logic [5:0]  FunctD,
  output logic        BranchHintD
`endif
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  state_t          state, state_nxt;
  logic [31:0]     pc, addr_q, redir_pc;
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   count;
  entry_t          mem [DEPTH];
  entry_t          head;
  logic            push, pop, can_req;

  assign redir_pc = RedirectPC & 32'hFFFF_FFFC;
  assign push     = (state == REQ) && ImemAck && !Redirect;
  assign pop      = InstrValid && InstrReady && !Redirect;
  // Free slot exists once this cycle's pop has been accounted for.
  assign can_req  = (count != FULL) || pop;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!Redirect && can_req) state_nxt = REQ;
      REQ:     if (ImemAck)              state_nxt = IDLE;
               else if (Redirect)        state_nxt = DISCARD;
      DISCARD: if (ImemAck)              state_nxt = IDLE;
      default:                           state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ImemReq  = (state != IDLE);
    ImemAddr = addr_q;
  end

  // addr_q latches the PC at issue so a redirect cannot disturb an in-flight address.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc     <= RESET_PC;
      addr_q <= RESET_PC;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (state == IDLE && state_nxt == REQ) addr_q <= pc;
      if (Redirect)  pc <= redir_pc;
      else if (push) pc <= pc + 32'd4;
      if (Redirect) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{pc: pc, instr: ImemRData};
  end

  assign head       = mem[rd_ptr];
  assign InstrValid = (count != '0);
  assign InstrD     = InstrValid ? head.instr : 32'h0;
  assign PCD        = InstrValid ? head.pc    : 32'h0;

`ifdef PREDECODE_EN
  // InstrD is already zero when empty, so the fields fall to zero with it.
  assign OpD         = InstrD[27:26];
  assign FunctD      = InstrD[25:20];
  assign BranchHintD = (OpD == 2'b10);
`endif

endmodule

// File: tb/tb_pipe_fetch_queue.sv
// Directed bench for pipe_fetch_queue: fetch order, backpressure, redirects, PC wrap and predecode.
module tb_pipe_fetch_queue;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        ImemReq, ImemAck, InstrValid, InstrReady, Redirect;
  logic [31:0] ImemAddr, ImemRData, InstrD, PCD, RedirectPC;
  logic        ImemReq2, ImemAck2, InstrValid2, InstrReady2, Redirect2;
  logic [31:0] ImemAddr2, ImemRData2, InstrD2, PCD2, RedirectPC2;
`ifdef PREDECODE_EN
  logic [1:0]  OpD, OpD2;
  logic [5:0]  FunctD, FunctD2;
  logic        BranchHintD, BranchHintD2;
`endif
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset_n(reset_n), .ImemReq(ImemReq), .ImemAddr(ImemAddr),
    .ImemAck(ImemAck), .ImemRData(ImemRData), .InstrValid(InstrValid),
    .InstrReady(InstrReady), .InstrD(InstrD), .PCD(PCD),
    .Redirect(Redirect), .RedirectPC(RedirectPC)
`ifdef PREDECODE_EN
    , .OpD(OpD), .FunctD(FunctD), .BranchHintD(BranchHintD)
`endif
  );

  pipe_fetch_queue #(.DEPTH(4), .RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset_n(reset_n), .ImemReq(ImemReq2), .ImemAddr(ImemAddr2),
    .ImemAck(ImemAck2), .ImemRData(ImemRData2), .InstrValid(InstrValid2),
    .InstrReady(InstrReady2), .InstrD(InstrD2), .PCD(PCD2),
    .Redirect(Redirect2), .RedirectPC(RedirectPC2)
`ifdef PREDECODE_EN
    , .OpD(OpD2), .FunctD(FunctD2), .BranchHintD(BranchHintD2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic ack_after(input int n, input logic [31:0] d);
    repeat (n) tick();
    ImemAck   = 1'b1;
    ImemRData = d;
    tick();
    ImemAck   = 1'b0;
  endtask

  // Leaves the bench in the first REQ cycle after reset release.
  task automatic do_reset;
    reset_n  = 1'b0;
    ImemAck  = 1'b0;
    Redirect = 1'b0;
    ImemAck2 = 1'b0;
    #1;
    chk("rst_req",   ImemReq,    0);
    chk("rst_vld",   InstrValid, 0);
    chk("rst_addr",  ImemAddr,   32'h0);
    chk("rst_instr", InstrD,     32'h0);
    chk("rst_pcd",   PCD,        32'h0);
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; ImemAck = 0; ImemRData = 0; InstrReady = 1; Redirect = 0; RedirectPC = 0;
    ImemAck2 = 0; ImemRData2 = 0; InstrReady2 = 1; Redirect2 = 0; RedirectPC2 = 0;

    // 1: streaming fetch; an ack in the first cycle after reset must be ignored.
    tick(); tick();
    chk("rst2_addr2", ImemAddr2, 32'hFFFF_FFFC);
    reset_n = 1'b1; ImemAck = 1'b1; ImemRData = 32'hDEAD_BEEF;
    tick();
    ImemAck = 1'b0;
    chk("t1_ign_vld", InstrValid, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t1_req",  ImemReq,  1);
      chk("t1_addr", ImemAddr, 32'(4 * i));
      ack_after(1, 32'hA000_0000 + 32'(i));
      chk("t1_vld",   InstrValid, 1);
      chk("t1_instr", InstrD,     32'hA000_0000 + 32'(i));
      chk("t1_pcd",   PCD,        32'(4 * i));
      chk("t1_noreq", ImemReq,    0);
      tick();
    end

    // 2: backpressure fills the FIFO, then fetch resumes at 0x10.
    do_reset();
    InstrReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t2_addr", ImemAddr, 32'(4 * i));
      ack_after(0, 32'hB000_0000 + 32'(i));
      chk("t2_head_pc", PCD,    32'h0);
      chk("t2_head_in", InstrD, 32'hB000_0000);
      if (i < 3) tick();
    end
    ImemAck = 1'b1; ImemRData = 32'hBAD0_BAD0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("t2_full_req", ImemReq, 0);
      chk("t2_full_pc",  PCD,     32'h0);
    end
    ImemAck = 1'b0; InstrReady = 1'b1;
    tick();
    chk("t2_res_req",  ImemReq,  1);
    chk("t2_res_addr", ImemAddr, 32'h10);
    chk("t2_pop1",     PCD,      32'h4);
    chk("t2_pop1_in",  InstrD,   32'hB000_0001);
    tick();
    chk("t2_pop2", PCD, 32'h8);
    tick();
    chk("t2_pop3", InstrD, 32'hB000_0003);
    tick();
    chk("t2_empty", InstrValid, 0);
    ack_after(0, 32'hC000_0000);
    chk("t2_new_pc", PCD,    32'h10);
    chk("t2_new_in", InstrD, 32'hC000_0000);

    // 3: redirect while the read to 0x8 is pending; ack arrives three cycles later.
    do_reset();
    InstrReady = 1'b0;
    ack_after(0, 32'hF000_0000);
    tick();
    ack_after(0, 32'hF000_0001);
    tick();
    chk("t3_addr8", ImemAddr,   32'h8);
    chk("t3_vld",   InstrValid, 1);
    Redirect = 1'b1; RedirectPC = 32'h103;
    tick();
    Redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("t3_hold_req",  ImemReq,    1);
      chk("t3_hold_addr", ImemAddr,   32'h8);
      chk("t3_flush",     InstrValid, 0);
      if (i < 2) tick();
    end
    ack_after(0, 32'hBAD0_0008);
    chk("t3_drop_vld", InstrValid, 0);
    chk("t3_drop_req", ImemReq,    0);
    tick();
    chk("t3_new_addr", ImemAddr, 32'h100);
    ack_after(0, 32'hF000_0100);
    chk("t3_new_pc", PCD,    32'h100);
    chk("t3_new_in", InstrD, 32'hF000_0100);

    // 4: redirect coincident with an ack and a pop.
    do_reset();
    InstrReady = 1'b0;
    ack_after(0, 32'h6000_0000);
    tick();
    chk("t4_pre_vld", InstrValid, 1);
    ImemAck = 1'b1; ImemRData = 32'h6000_0001; Redirect = 1'b1; RedirectPC = 32'h40; InstrReady = 1'b1;
    tick();
    ImemAck = 1'b0; Redirect = 1'b0;
    chk("t4_flush", InstrValid, 0);
    chk("t4_req0",  ImemReq,    0);
    tick();
    chk("t4_addr", ImemAddr, 32'h40);
    ack_after(0, 32'h6000_0040);
    chk("t4_pc", PCD,    32'h40);
    chk("t4_in", InstrD, 32'h6000_0040);

    // 5: PC wrap from the top of the address space.
    do_reset();
    chk("t5_req",  ImemReq2,  1);
    chk("t5_addr", ImemAddr2, 32'hFFFF_FFFC);
    ImemAck2 = 1'b1; ImemRData2 = 32'h1234_5678;
    tick();
    ImemAck2 = 1'b0;
    chk("t5_pcd",  PCD2,    32'hFFFF_FFFC);
    chk("t5_in",   InstrD2, 32'h1234_5678);
    tick();
    chk("t5_wrap", ImemAddr2, 32'h0);

`ifdef PREDECODE_EN
    // 6: predecode fields from the FIFO head.
    do_reset();
    InstrReady = 1'b0;
    ack_after(0, 32'hEA00_0004);
    chk("t6_op_b",   OpD,         2'b10);
    chk("t6_fn_b",   FunctD,      6'b100000);
    chk("t6_hint_b", BranchHintD, 1);
    InstrReady = 1'b1;
    tick();
    chk("t6_op_empty",   OpD,         0);
    chk("t6_hint_empty", BranchHintD, 0);
    ack_after(0, 32'hE591_2000);
    chk("t6_op_l",   OpD,         2'b01);
    chk("t6_fn_l",   FunctD,      6'b011001);
    chk("t6_hint_l", BranchHintD, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
